// File: rtl/pll_lock_sequencer_if.sv
// PLL supervision bundle between the lock sequencer (master) and its
// environment: PLL LOCK / software request in, PLL and system resets plus status out.
interface pll_lock_sequencer_if;
  logic       locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] loss_count;
  logic [3:0] timeout_count;

  modport master (
    input  locked, force_relock,
    output pll_rst, sys_rst, ready, loss_count, timeout_count
  );

  modport slave (
    output locked, force_relock,
    input  pll_rst, sys_rst, ready, loss_count, timeout_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// ECP5 EHXPLLL power-up / lock supervisor on the free-running reference clock.
// Optional lock watchdog enabled by defining PLL_LOCK_WATCHDOG_EN.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                 clk,
  input  logic                 rst,
  pll_lock_sequencer_if.master bus
);

  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("RST_CYCLES must be >= 1");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $error("STABLE_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

`ifdef PLL_LOCK_WATCHDOG_EN
  localparam int unsigned CNT_MAX = max2(max2(RST_CYCLES, STABLE_CYCLES), TIMEOUT_CYCLES);
`else
  localparam int unsigned CNT_MAX = max2(RST_CYCLES, STABLE_CYCLES);
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef PLL_LOCK_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic [7:0]       loss_q, loss_d;
  logic             pll_rst_q, sys_rst_q, ready_q;
  logic             locked_s;
`ifdef PLL_LOCK_WATCHDOG_EN
  logic [3:0]       tmo_q, tmo_d;
`endif

  assign locked_s = sync_q[1];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    loss_d  = loss_q;
`ifdef PLL_LOCK_WATCHDOG_EN
    tmo_d   = tmo_q;
`endif

    // Priority: software relock, then watchdog, then the synchronized lock level.
    unique case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (bus.force_relock) begin
          state_d = RESET_PLL;
`ifdef PLL_LOCK_WATCHDOG_EN
        end else if (cnt_q == TMO_LAST) begin
          state_d = RESET_PLL;
          if (tmo_q != 4'hF) tmo_d = tmo_q + 4'd1;
`endif
        end else if (locked_s) begin
          state_d = STABLE;
        end
      end
      STABLE: begin
        if (bus.force_relock)         state_d = RESET_PLL;
        else if (!locked_s)           state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RUN;
      end
      RUN: begin
        if (bus.force_relock) begin
          state_d = RESET_PLL;
        end else if (!locked_s) begin
          state_d = WAIT_LOCK;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      default: state_d = RESET_PLL;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b00;
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      loss_q    <= 8'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
`ifdef PLL_LOCK_WATCHDOG_EN
      tmo_q     <= 4'd0;
`endif
    end else begin
      sync_q    <= {sync_q[0], bus.locked};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      loss_q    <= loss_d;
      // Outputs register the decode of the next state so they track state_q exactly.
      pll_rst_q <= (state_d == RESET_PLL);
      sys_rst_q <= (state_d != RUN);
      ready_q   <= (state_d == RUN);
`ifdef PLL_LOCK_WATCHDOG_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign bus.pll_rst    = pll_rst_q;
  assign bus.sys_rst    = sys_rst_q;
  assign bus.ready      = ready_q;
  assign bus.loss_count = loss_q;
`ifdef PLL_LOCK_WATCHDOG_EN
  assign bus.timeout_count = tmo_q;
`else
  assign bus.timeout_count = 4'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer with RST=4, STABLE=8, TIMEOUT=32.
// Works with or without PLL_LOCK_WATCHDOG_EN defined.
module tb_pll_lock_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pll_lock_sequencer_if bus();

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .STABLE_CYCLES (8),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       name;
    logic [14:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t x;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Packed view {pll_rst, sys_rst, ready, loss_count, timeout_count}.
  function automatic logic [14:0] word(input logic p, input logic s, input logic r,
                                       input logic [7:0] l, input logic [3:0] t);
    return {p, s, r, l, t};
  endfunction

  function automatic logic [14:0] snap();
    return {bus.pll_rst, bus.sys_rst, bus.ready, bus.loss_count, bus.timeout_count};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst released just after an edge, so the next posedge is edge 1.
  task automatic do_reset(input logic lk);
    bus.locked       = lk;
    bus.force_relock = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.locked       = 1'b0;
    bus.force_relock = 1'b0;
    rst = 1'b1;
    step();
    step();
    sb.push_back('{"reset_values", word(1'b1, 1'b1, 1'b0, 8'd0, 4'd0)});
    x = sb.pop_front(); n_tests++;
    if (snap() !== x.val) begin
      n_fail++; $display("FAIL %s: observed %h required %h", x.name, snap(), x.val);
    end
    rst = 1'b0;
  endtask

  task automatic test_power_up();
    do_reset(1'b0);
    for (int e = 1; e <= 22; e++) begin
      sb.push_back('{$sformatf("power_up_e%0d", e),
                     word(e < 4, e < 21, e >= 21, 8'd0, 4'd0)});
      step();
      x = sb.pop_front(); n_tests++;
      if (snap() !== x.val) begin
        n_fail++; $display("FAIL %s: observed %h required %h", x.name, snap(), x.val);
      end
      if (e == 10) bus.locked = 1'b1;
    end
  endtask

  task automatic test_unstable();
    do_reset(1'b0);
    for (int e = 1; e <= 30; e++) begin
      sb.push_back('{$sformatf("unstable_e%0d", e),
                     word(e < 4, e < 29, e >= 29, 8'd0, 4'd0)});
      step();
      x = sb.pop_front(); n_tests++;
      if (snap() !== x.val) begin
        n_fail++; $display("FAIL %s: observed %h required %h", x.name, snap(), x.val);
      end
      if (e == 10) bus.locked = 1'b1;
      if (e == 15) bus.locked = 1'b0;
      if (e == 18) bus.locked = 1'b1;
    end
  endtask

  // Entered in RUN with loss_count 0.
  task automatic test_lock_loss();
    int exp_loss;
    for (int i = 1; i <= 300; i++) begin
      exp_loss = (i > 255) ? 255 : i;
      bus.locked = 1'b0;
      sb.push_back('{$sformatf("loss_%0d", i),
                     word(1'b0, 1'b1, 1'b0, 8'(exp_loss), 4'd0)});
      step();
      step();
      if (i == 1) begin
        n_tests++;
        if (bus.ready !== 1'b1) begin
          n_fail++; $display("FAIL loss_latency_2: ready observed %b required 1", bus.ready);
        end
      end
      step();
      x = sb.pop_front(); n_tests++;
      if (snap() !== x.val) begin
        n_fail++; $display("FAIL %s: observed %h required %h", x.name, snap(), x.val);
      end
      bus.locked = 1'b1;
      for (int k = 0; k < 20 && bus.ready !== 1'b1; k++) step();
      n_tests++;
      if (bus.ready !== 1'b1) begin
        n_fail++; $display("FAIL relock_%0d: ready observed %b required 1 within 20 cycles", i, bus.ready);
      end
    end
  endtask

  task automatic test_force_relock();
    do_reset(1'b1);
    for (int k = 0; k < 40 && bus.ready !== 1'b1; k++) step();
    bus.locked = 1'b0;
    step(); step(); step();
    bus.locked = 1'b1;
    for (int k = 0; k < 40 && bus.ready !== 1'b1; k++) step();
    sb.push_back('{"force_pre_run", word(1'b0, 1'b0, 1'b1, 8'd1, 4'd0)});
    x = sb.pop_front(); n_tests++;
    if (snap() !== x.val) begin
      n_fail++; $display("FAIL %s: observed %h required %h", x.name, snap(), x.val);
    end
    // Lock loss reaches locked_s two edges later; request relock on that same cycle.
    bus.locked = 1'b0;
    step(); step();
    bus.force_relock = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      sb.push_back('{$sformatf("force_entry_p%0d", e),
                     word(e < 4, 1'b1, 1'b0, 8'd1, 4'd0)});
      step();
      bus.force_relock = (e == 0);  // second pulse lands inside RESET_PLL and is ignored
      x = sb.pop_front(); n_tests++;
      if (snap() !== x.val) begin
        n_fail++; $display("FAIL %s: observed %h required %h", x.name, snap(), x.val);
      end
    end
    bus.force_relock = 1'b0;
  endtask

  task automatic test_watchdog();
`ifdef PLL_LOCK_WATCHDOG_EN
    do_reset(1'b0);
    for (int e = 1; e <= 40; e++) begin
      sb.push_back('{$sformatf("wdog_e%0d", e),
                     word((e < 4) || (e >= 36 && e < 40), 1'b1, 1'b0, 8'd0,
                          (e >= 36) ? 4'd1 : 4'd0)});
      step();
      x = sb.pop_front(); n_tests++;
      if (snap() !== x.val) begin
        n_fail++; $display("FAIL %s: observed %h required %h", x.name, snap(), x.val);
      end
    end
    for (int k = 0; k < 20 * 36; k++) step();
    sb.push_back('{"wdog_saturate", {11'd0, 4'd15}});
    x = sb.pop_front(); n_tests++;
    if ({11'd0, bus.timeout_count} !== x.val) begin
      n_fail++; $display("FAIL %s: observed %h required %h", x.name, {11'd0, bus.timeout_count}, x.val);
    end
`else
    logic saw_pulse;
    do_reset(1'b0);
    step(); step(); step(); step();
    sb.push_back('{"no_wdog_e4", word(1'b0, 1'b1, 1'b0, 8'd0, 4'd0)});
    x = sb.pop_front(); n_tests++;
    if (snap() !== x.val) begin
      n_fail++; $display("FAIL %s: observed %h required %h", x.name, snap(), x.val);
    end
    saw_pulse = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (bus.pll_rst !== 1'b0 || bus.timeout_count !== 4'd0) saw_pulse = 1'b1;
    end
    sb.push_back('{"no_wdog_1000", word(1'b0, 1'b1, 1'b0, 8'd0, 4'd0)});
    x = sb.pop_front(); n_tests++;
    if (snap() !== x.val || saw_pulse !== 1'b0) begin
      n_fail++; $display("FAIL %s: observed %h pulse_seen %b required %h pulse_seen 0",
                         x.name, snap(), saw_pulse, x.val);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    for (int k = 0; k < 40 && bus.ready !== 1'b1; k++) step();
    bus.locked = 1'b0;
    step(); step(); step();
    sb.push_back('{"mid_loss", word(1'b0, 1'b1, 1'b0, 8'd1, 4'd0)});
    x = sb.pop_front(); n_tests++;
    if (snap() !== x.val) begin
      n_fail++; $display("FAIL %s: observed %h required %h", x.name, snap(), x.val);
    end
    bus.locked = 1'b1;
    step(); step(); step(); step(); step();  // STABLE entered on the third edge
    #2;
    rst = 1'b1;
    #1;
    sb.push_back('{"mid_async_reset", word(1'b1, 1'b1, 1'b0, 8'd0, 4'd0)});
    x = sb.pop_front(); n_tests++;
    if (snap() !== x.val) begin
      n_fail++; $display("FAIL %s: observed %h required %h", x.name, snap(), x.val);
    end
    step();
    rst = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      sb.push_back('{$sformatf("mid_restart_e%0d", e),
                     word(e < 4, e < 13, e >= 13, 8'd0, 4'd0)});
      step();
      x = sb.pop_front(); n_tests++;
      if (snap() !== x.val) begin
        n_fail++; $display("FAIL %s: observed %h required %h", x.name, snap(), x.val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_unstable();
    test_lock_loss();
    test_force_relock();
    test_watchdog();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Power-up and lock-supervision controller for the ECP5 EHXPLLL clock generator. It drives the PLL `RST` pin, supervises the asynchronous `LOCK` output, and holds the downstream system reset until lock has been stable for a programmable time. It re-sequences on lock loss, software request or (optionally) lock timeout. It runs on the free-running 20 MHz board clock that feeds the PLL `CLKI`, never on the PLL output.

## Interface
- `RST_CYCLES`, default 16: PLL reset pulse length in clk cycles (≥1).
- `STABLE_CYCLES`, default 1024: cycles `locked` must stay high before release (≥1).
- `TIMEOUT_CYCLES`, default 65536: watchdog lock timeout (≥1; used only with the watchdog feature).
- `clk` input, 1 bit: free-running reference clock, same net as PLL `CLKI`.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `locked` input, 1 bit: PLL `LOCK`, asynchronous to `clk`.
- `force_relock` input, 1 bit: single-cycle software relock request, synchronous to `clk`.
- `pll_rst` output, 1 bit: drives PLL `RST`.
- `sys_rst` output, 1 bit: reset for PLL-clocked logic (the consumer synchronizes the deassertion).
- `ready` output, 1 bit: high only in RUN.
- `loss_count` output, 8 bits: saturating count of lock losses seen in RUN.
- `timeout_count` output, 4 bits: saturating count of watchdog retries.

## Operation
- `locked` passes through a 2-flop synchronizer to give `locked_s`. Only `locked_s` is used.
- There is one shared cycle counter, sized to hold max(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES). It clears on every state entry.
- States and transitions:
  - RESET_PLL: reset state. `pll_rst`=1. When the counter reaches RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: if `locked_s`, go to STABLE. Otherwise, with the watchdog compiled in and the counter at TIMEOUT_CYCLES-1, go to RESET_PLL and increment `timeout_count` (saturating at 15).
  - STABLE: if `!locked_s`, go to WAIT_LOCK. Otherwise, when the counter reaches STABLE_CYCLES-1, go to RUN.
  - RUN: if `!locked_s`, go to WAIT_LOCK and increment `loss_count` (saturating at 255).
- Output decode is Moore, taken from the registered state:
  - `pll_rst` = (state==RESET_PLL).
  - `sys_rst` = (state!=RUN).
  - `ready` = (state==RUN).
- `force_relock`=1 sends any state other than RESET_PLL to RESET_PLL on the next edge. In RESET_PLL it is ignored and the pulse is not restarted.
- Event priority: `force_relock` > watchdog timeout > `locked_s` change. If `force_relock` and lock loss occur together in RUN, go to RESET_PLL and leave `loss_count` unchanged.
- Counters saturate. They never wrap.
- `rst` asserted at any time, including mid-sequence, gives immediately:
  - state RESET_PLL, counter 0;
  - synchronizer flops 0;
  - `pll_rst`=1, `sys_rst`=1, `ready`=0, `loss_count`=0, `timeout_count`=0.

## Timing
- Reset values: `pll_rst`=1, `sys_rst`=1, `ready`=0, `loss_count`=0, `timeout_count`=0.
- `pll_rst` stays high for exactly RST_CYCLES rising edges after `rst` deasserts. The same holds for each RESET_PLL entry, counted from the entry edge.
- `locked` rise to `locked_s` rise: 2 edges. `locked_s` rise to STABLE: 1 edge.
- From entering STABLE to `ready`=1: STABLE_CYCLES edges, provided `locked_s` stays high throughout.
- Lock loss in RUN to `sys_rst`=1: 3 edges (2 synchronizer edges + 1 state edge). `loss_count` updates on the same edge.
- A `locked` glitch of one cycle or shorter may or may not be captured. If `locked_s` shows a glitch, it must be acted on.
- `force_relock` to `pll_rst`=1: 1 edge.

## Configuration
- Macro: `PLL_LOCK_WATCHDOG_EN`.
- Defined: WAIT_LOCK times out after TIMEOUT_CYCLES and retries through RESET_PLL. `timeout_count` is live.
- Undefined: WAIT_LOCK waits indefinitely. No timeout comparator is built, and `timeout_count` is tied to 0. The counter is sized from RST_CYCLES and STABLE_CYCLES only.

## Test plan
All scenarios use parameters RST=4, STABLE=8, TIMEOUT=32 unless stated.
- Power-up: deassert `rst`, raise `locked` at cycle 10 → `pll_rst` falls at edge 4; `ready`=1 and `sys_rst`=0 at edge 10+2+1+8=21; both counts 0.
- Unstable lock: `locked` high for 5 cycles, low for 3, then high → sequencer returns to WAIT_LOCK with `ready` never asserted; `ready` rises 8 cycles after STABLE is re-entered.
- Lock loss: in RUN, drop `locked` → `sys_rst`=1 and `ready`=0 after 3 edges, `loss_count`=1. Repeat 300 times → `loss_count`=255.
- Watchdog (macro defined): hold `locked` low → `pll_rst` pulses for 4 cycles every 36 cycles; `timeout_count` increments, saturating at 15. Macro undefined → no second pulse after 1000 cycles and `timeout_count`=0.
- Software relock: pulse `force_relock` in RUN, in the same cycle as lock loss → RESET_PLL on the next edge, `pll_rst` high for 4 cycles, `loss_count` unchanged.
- Reset mid-sequence: assert `rst` asynchronously while in STABLE → all outputs return to reset values without waiting for a clock edge; after release, the full sequence restarts from RESET_PLL.
